// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and helpers
//
// Purpose: word width and receive-buffer geometry shared by the UART blocks,
// plus a small helper for sizing occupancy comparisons.
// Ports: none (package).
package uart_pkg;

    localparam int UART_DATA_W         = 8;
    localparam int UART_RXF_ADDR_W     = 8;
    localparam int UART_RXF_AF_DEFAULT = 224;

    // Number of words held by a buffer addressed with addr_w bits.
    function automatic int uart_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/uart_fifo_ram.sv
// rtl/uart_fifo_ram.sv - storage array for the UART receive buffer
//
// Purpose: DATA_W x 2**ADDR_W memory with one synchronous write port and one
// asynchronous read port. Contents are not reset, so it maps onto RAM/LUTRAM.
// Ports:
//   clk    in   1        write clock
//   we     in   1        write enable
//   waddr  in   ADDR_W   write address
//   wdata  in   DATA_W   write data
//   raddr  in   ADDR_W   read address
//   rdata  out  DATA_W   read data, combinational from raddr
module uart_fifo_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo_p.sv
// rtl/uart_rx_fifo_p.sv - parametrised UART receive FIFO with show-ahead read
//
// Purpose: captures one word per rising edge of the receiver ready strobe and
// presents the oldest word show-ahead to the CPU port. Never overwrites unread
// data; a write into a full buffer is dropped and recorded in a sticky flag.
// Ports:
//   clk          in   1         single clock
//   rst          in   1         synchronous active-high reset
//   rdy          in   1         receiver ready level; a write per rising edge
//   din          in   DATA_W    received word
//   next         in   1         pop request, one word per cycle while high
//   flush        in   1         discard all buffered words
//   ovf_clr      in   1         clear the sticky overflow flag
//   data         out  DATA_W    oldest word, 0 when empty
//   in_waiting   out  ADDR_W+1  occupancy 0..DEPTH
//   empty        out  1         no words stored
//   full         out  1         DEPTH words stored
//   almost_full  out  1         occupancy >= AF_THRESH
//   overflow     out  1         sticky: a write was dropped while full
module uart_rx_fifo_p
    import uart_pkg::*;
#(
    parameter int DATA_W    = UART_DATA_W,
    parameter int ADDR_W    = UART_RXF_ADDR_W,
    parameter int AF_THRESH = UART_RXF_AF_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic [DATA_W-1:0] din,
    input  logic              next,
    input  logic              flush,
    input  logic              ovf_clr,
    output logic [DATA_W-1:0] data,
    output logic [ADDR_W:0]   in_waiting,
    output logic              empty,
    output logic              full,
    output logic              almost_full,
    output logic              overflow
);

    localparam int            DEPTH  = uart_depth(ADDR_W);
    localparam logic [ADDR_W:0] AF_LVL = (ADDR_W + 1)'(AF_THRESH);

    // One extra pointer bit distinguishes full from empty when the low bits match.
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic              rdy_q;
    logic              ovf_q;

    logic              push;
    logic              pop;
    logic              wr_en;
    logic              drop;
    logic [DATA_W-1:0] rd_data;

    assign empty       = (wr_ptr == rd_ptr);
    assign full        = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                         (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign in_waiting  = wr_ptr - rd_ptr;
    assign almost_full = (in_waiting >= AF_LVL);
    assign overflow    = ovf_q;

    // A high-level rdy counts once, on the cycle it rises.
    assign push = rdy & ~rdy_q;
    assign pop  = next & ~empty;

    // When full, a simultaneous pop frees the slot the write lands in, so both
    // proceed. Flush discards any write in the same cycle without flagging it.
    assign wr_en = push & (~full | pop) & ~flush & ~rst;
    assign drop  = push & full & ~pop & ~flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            // Starting high suppresses a write if rdy is already high at release.
            rdy_q  <= 1'b1;
            ovf_q  <= 1'b0;
        end else begin
            rdy_q <= rdy;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_en) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
            end
            // A drop in the same cycle as a clear leaves the flag set.
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end

    uart_fifo_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr[ADDR_W-1:0]),
        .wdata (din),
        .raddr (rd_ptr[ADDR_W-1:0]),
        .rdata (rd_data)
    );

    // Memory is not reset, so mask stale contents while nothing is stored.
    assign data = empty ? '0 : rd_data;

    if (DEPTH < 2) begin : g_bad_depth
        $error("uart_rx_fifo_p needs ADDR_W >= 1");
    end

endmodule
